adc_sample_averager: RTL and testbench

ADC_SAMPLE_AVERAGER -- requirements
Module: adc_sample_averager

---
 rtl/adc_pkg.sv | 43 ++++
 rtl/adc_accumulator.sv | 46 ++++
 rtl/adc_sample_averager.sv | 170 +++++++++++++++++
 tb/tb_adc_sample_averager.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// adc_pkg -- definitions shared by the sample averager and the ADC interface.
//   state_t    : averager sequencer states
//   OP_*       : adc_op command codes driven with adc_cs
//   adc_cmd_t  : one command-strobe bundle (cs, op, addr)
//   mk_cmd     : builds a strobe for a command code and channel
package adc_pkg;

   localparam int ADC_W = 14;

   localparam logic [3:0] OP_SEL  = 4'b0000;
   localparam logic [3:0] OP_RST  = 4'b0001;
   localparam logic [3:0] OP_CONV = 4'b0010;

   typedef enum logic [3:0] {
      S_IDLE,
      S_ADC_RST,
      S_TRIG,
      S_WAIT_LO,
      S_WAIT_HI,
      S_SEL_A,
      S_RD_A,
      S_SEL_B,
      S_RD_B,
      S_ACC,
      S_OUT
   } state_t;

   typedef struct packed {
      logic       cs;
      logic [3:0] op;
      logic [7:0] addr;
   } adc_cmd_t;

   // Channel lives in addr bit 0; the upper address bits are always zero.
   function automatic adc_cmd_t mk_cmd(input logic [3:0] op, input logic ch);
      adc_cmd_t c;
      c.cs   = 1'b1;
      c.op   = op;
      c.addr = {7'b0, ch};
      return c;
   endfunction

endpackage

// File: rtl/adc_accumulator.sv
// adc_accumulator -- dual-channel clear/add accumulator with shift average.
//   clk, rst     : clock, synchronous active-high reset
//   clr          : zero both accumulators (wins over add)
//   add          : acc_x <= acc_x + in_x
//   in_a, in_b   : W-bit unsigned samples
//   avg_a, avg_b : (acc_x + in_x) >> SHIFT, i.e. the average that includes the
//                  sample currently presented, so the caller can capture the
//                  final result on the same cycle it adds the last sample
// Accumulators are W+SHIFT bits: 2^SHIFT samples of W bits cannot overflow.
module adc_accumulator #(
   parameter int W     = 14,
   parameter int SHIFT = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         add,
   input  logic [W-1:0] in_a,
   input  logic [W-1:0] in_b,
   output logic [W-1:0] avg_a,
   output logic [W-1:0] avg_b
);

   localparam int AW = W + SHIFT;

   logic [AW-1:0] acc_a, acc_b;
   logic [AW-1:0] sum_a, sum_b;

   assign sum_a = acc_a + AW'(in_a);
   assign sum_b = acc_b + AW'(in_b);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         acc_a <= '0;
         acc_b <= '0;
      end else if (add) begin
         acc_a <= sum_a;
         acc_b <= sum_b;
      end
   end

   // Truncating divide by 2^SHIFT.
   assign avg_a = sum_a[AW-1:SHIFT];
   assign avg_b = sum_b[AW-1:SHIFT];

endmodule

// File: rtl/adc_sample_averager.sv
// adc_sample_averager -- sequences a two-channel ADC, averages 2^LOG2_AVG
// conversions per channel and hands the result over a valid/ready port.
//   clk, rst           : clock, synchronous active-high reset
//   run                : level; acquisitions repeat while high
//   adc_cs/op/addr     : command strobe to the ADC interface
//   adc_rdy, adc_data  : ADC idle flag and selected-channel result
//   avg_a, avg_b       : averaged results, valid while out_valid
//   out_valid/out_ready: result handshake
//   busy               : high in every state except IDLE
//   err_timeout        : sticky, set when a wait on adc_rdy runs out
module adc_sample_averager
   import adc_pkg::*;
#(
   parameter int LOG2_AVG = 2,
   parameter int TIMEOUT  = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              run,
   output logic              adc_cs,
   output logic [3:0]        adc_op,
   output logic [7:0]        adc_addr,
   input  logic              adc_rdy,
   input  logic [ADC_W-1:0]  adc_data,
   output logic [ADC_W-1:0]  avg_a,
   output logic [ADC_W-1:0]  avg_b,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              busy,
   output logic              err_timeout
);

   localparam int NSAMP = 1 << LOG2_AVG;
   localparam int CW    = LOG2_AVG + 1;
   localparam int TW    = $clog2(TIMEOUT + 1);

   state_t             state, next_state;
   logic               in_rst;
   logic [TW-1:0]      wait_cnt;
   logic               settled;
   logic [ADC_W-1:0]   sample_a, sample_b;
   logic [CW-1:0]      count;
   logic [ADC_W-1:0]   avg_next_a, avg_next_b;
   logic               in_wait, timeout_hit, timeout_ev, last;
   logic               acc_add, acc_clr;
   adc_cmd_t           cmd;

   assign in_wait     = (state == S_WAIT_LO) || (state == S_WAIT_HI);
   assign timeout_hit = in_wait && (wait_cnt == TW'(TIMEOUT - 1));
   // Timeout only counts when the awaited edge has not shown up this cycle.
   assign timeout_ev  = timeout_hit && ((state == S_WAIT_LO) ? adc_rdy : !adc_rdy);
   assign last        = (count == CW'(NSAMP - 1));

   assign acc_add = (state == S_ACC);
   assign acc_clr = timeout_ev || ((state == S_ACC) && last);

   adc_accumulator #(
      .W     (ADC_W),
      .SHIFT (LOG2_AVG)
   ) u_acc (
      .clk   (clk),
      .rst   (rst),
      .clr   (acc_clr),
      .add   (acc_add),
      .in_a  (sample_a),
      .in_b  (sample_b),
      .avg_a (avg_next_a),
      .avg_b (avg_next_b)
   );

   // State register. in_rst marks the cycles while rst is held, so ADC_RST
   // keeps every output quiet and issues its strobe only once rst is gone.
   always_ff @(posedge clk) begin
      in_rst <= rst;
      if (rst) state <= S_ADC_RST;
      else     state <= next_state;
   end

   // Next state.
   always_comb begin
      next_state = state;
      unique case (state)
         S_IDLE:    if (run && adc_rdy) next_state = S_TRIG;
         S_ADC_RST: if (!in_rst) next_state = S_IDLE;
         S_TRIG:    next_state = S_WAIT_LO;
         S_WAIT_LO: begin
            if (!adc_rdy)         next_state = S_WAIT_HI;
            else if (timeout_hit) next_state = S_ADC_RST;
         end
         S_WAIT_HI: begin
            if (adc_rdy)          next_state = S_SEL_A;
            else if (timeout_hit) next_state = S_ADC_RST;
         end
         S_SEL_A:   next_state = S_RD_A;
         // RD_x spends one settle cycle, then samples on the second.
         S_RD_A:    if (settled) next_state = S_SEL_B;
         S_SEL_B:   next_state = S_RD_B;
         S_RD_B:    if (settled) next_state = S_ACC;
         S_ACC: begin
            if (last)     next_state = S_OUT;
            else if (run) next_state = S_TRIG;
            else          next_state = S_IDLE;
         end
         S_OUT:     if (out_ready) next_state = S_IDLE;
         default:   next_state = S_ADC_RST;
      endcase
   end

   // Outputs: command strobes decoded from state.
   always_comb begin
      cmd = '0;
      if (!in_rst) begin
         case (state)
            S_ADC_RST: cmd = mk_cmd(OP_RST,  1'b0);
            S_TRIG:    cmd = mk_cmd(OP_CONV, 1'b0);
            S_SEL_A:   cmd = mk_cmd(OP_SEL,  1'b0);
            S_SEL_B:   cmd = mk_cmd(OP_SEL,  1'b1);
            default:   cmd = '0;
         endcase
      end
   end

   assign adc_cs   = cmd.cs;
   assign adc_op   = cmd.op;
   assign adc_addr = cmd.addr;
   assign busy     = (state != S_IDLE) && !in_rst;

   // Datapath: wait counter, settle flag, sample capture, count, result.
   always_ff @(posedge clk) begin
      if (rst) begin
         wait_cnt    <= '0;
         settled     <= 1'b0;
         sample_a    <= '0;
         sample_b    <= '0;
         count       <= '0;
         avg_a       <= '0;
         avg_b       <= '0;
         out_valid   <= 1'b0;
         err_timeout <= 1'b0;
      end else begin
         // Cleared on every state change, so each wait state starts at zero.
         if (in_wait && (next_state == state)) wait_cnt <= wait_cnt + 1'b1;
         else                                  wait_cnt <= '0;

         settled <= ((state == S_RD_A) || (state == S_RD_B)) && !settled;

         if ((state == S_RD_A) && settled) sample_a <= adc_data;
         if ((state == S_RD_B) && settled) sample_b <= adc_data;

         if (timeout_ev) begin
            err_timeout <= 1'b1;
            count       <= '0;
         end

         if (state == S_ACC) begin
            if (last) begin
               count     <= '0;
               avg_a     <= avg_next_a;
               avg_b     <= avg_next_b;
               out_valid <= 1'b1;
            end else begin
               count <= count + 1'b1;
            end
         end

         if ((state == S_OUT) && out_ready) out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_adc_sample_averager.sv
// Bench for adc_sample_averager: a behavioural two-channel ADC model feeds
// each DUT; expected averages are computed from the served conversions and
// queued, and a monitor pops and compares on every output transfer.
module tb_adc_sample_averager;
   import adc_pkg::*;

   localparam int L2    = 2;
   localparam int N_AVG = 1 << L2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        run = 1'b0;
   logic        adc_cs;
   logic [3:0]  adc_op;
   logic [7:0]  adc_addr;
   logic        adc_rdy = 1'b1;
   logic [13:0] adc_data = '0;
   logic [13:0] avg_a, avg_b;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic        busy, err_timeout;

   logic        run0 = 1'b0;
   logic        adc_cs0;
   logic [3:0]  adc_op0;
   logic [7:0]  adc_addr0;
   logic        adc_rdy0 = 1'b1;
   logic [13:0] adc_data0 = '0;
   logic [13:0] avg_a0, avg_b0;
   logic        out_valid0;
   logic        out_ready0 = 1'b1;
   logic        busy0, err_timeout0;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   adc_sample_averager #(.LOG2_AVG(L2), .TIMEOUT(16)) dut (
      .clk(clk), .rst(rst), .run(run),
      .adc_cs(adc_cs), .adc_op(adc_op), .adc_addr(adc_addr),
      .adc_rdy(adc_rdy), .adc_data(adc_data),
      .avg_a(avg_a), .avg_b(avg_b), .out_valid(out_valid), .out_ready(out_ready),
      .busy(busy), .err_timeout(err_timeout));

   adc_sample_averager #(.LOG2_AVG(0), .TIMEOUT(16)) dut0 (
      .clk(clk), .rst(rst), .run(run0),
      .adc_cs(adc_cs0), .adc_op(adc_op0), .adc_addr(adc_addr0),
      .adc_rdy(adc_rdy0), .adc_data(adc_data0),
      .avg_a(avg_a0), .avg_b(avg_b0), .out_valid(out_valid0), .out_ready(out_ready0),
      .busy(busy0), .err_timeout(err_timeout0));

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
      end
   endtask

   // ---------------- ADC model (main DUT) ----------------
   int va_q[$], vb_q[$];        // forced conversion values, else random
   int exp_a[$], exp_b[$];      // scoreboard
   int cur_a = 0, cur_b = 0;
   int psum_a = 0, psum_b = 0, pcnt = 0;
   int clr_gen = 0, clr_seen = 0;
   int busy_cnt = 0;
   int trig_cnt = 0;
   int xfer_cnt = 0;
   bit stuck = 1'b0;
   bit sel = 1'b0;

   always @(negedge clk) begin
      if (clr_gen != clr_seen) begin
         psum_a = 0; psum_b = 0; pcnt = 0;
         clr_seen = clr_gen;
      end
      if (adc_cs && adc_op == OP_CONV) begin
         trig_cnt++;
         if (!stuck) begin
            if (va_q.size() > 0) begin
               cur_a = va_q.pop_front();
               cur_b = vb_q.pop_front();
            end else begin
               cur_a = int'($urandom_range(0, 16383));
               cur_b = int'($urandom_range(0, 16383));
            end
            psum_a += cur_a; psum_b += cur_b; pcnt++;
            if (pcnt == N_AVG) begin
               exp_a.push_back(psum_a / N_AVG);
               exp_b.push_back(psum_b / N_AVG);
               psum_a = 0; psum_b = 0; pcnt = 0;
            end
            adc_rdy  = 1'b0;
            busy_cnt = int'($urandom_range(2, 5));
         end
      end else if (!adc_rdy) begin
         busy_cnt--;
         if (busy_cnt <= 0) adc_rdy = 1'b1;
      end
      if (adc_cs && adc_op == OP_SEL) sel = adc_addr[0];
      if (adc_cs && adc_op == OP_RST) sel = 1'b0;
      adc_data = sel ? 14'(cur_b) : 14'(cur_a);
   end

   // ---------------- ADC model (LOG2_AVG=0 DUT): A=5, B=9 ----------------
   int trig0 = 0, busy0_cnt = 0, xfer0 = 0;
   bit sel0 = 1'b0;

   always @(negedge clk) begin
      if (adc_cs0 && adc_op0 == OP_CONV) begin
         trig0++;
         adc_rdy0  = 1'b0;
         busy0_cnt = 2;
      end else if (!adc_rdy0) begin
         busy0_cnt--;
         if (busy0_cnt <= 0) adc_rdy0 = 1'b1;
      end
      if (adc_cs0 && adc_op0 == OP_SEL) sel0 = adc_addr0[0];
      adc_data0 = sel0 ? 14'd9 : 14'd5;
   end

   // ---------------- monitor ----------------
   always begin
      @(negedge clk);
      #2;
      if (!rst && out_valid && out_ready) begin
         if (exp_a.size() == 0) begin
            checks++; failures++;
            $display("FAIL sb_unexpected actual=%0d/%0d required=none", avg_a, avg_b);
         end else begin
            check("sb_avg_a", 32'(avg_a), 32'(exp_a.pop_front()));
            check("sb_avg_b", 32'(avg_b), 32'(exp_b.pop_front()));
         end
         xfer_cnt++;
      end
      if (!rst && out_valid0 && out_ready0) begin
         xfer0++;
         check("raw_avg_a", 32'(avg_a0), 32'd5);
         check("raw_avg_b", 32'(avg_b0), 32'd9);
         check("raw_trig_per_result", 32'(trig0), 32'(xfer0));
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic push_fixed(input int a0, a1, a2, a3, b0, b1, b2, b3);
      va_q.push_back(a0); va_q.push_back(a1); va_q.push_back(a2); va_q.push_back(a3);
      vb_q.push_back(b0); vb_q.push_back(b1); vb_q.push_back(b2); vb_q.push_back(b3);
   endtask

   task automatic check_all_zero(input string nm);
      check({nm, "_avg_a"}, 32'(avg_a), 0);
      check({nm, "_avg_b"}, 32'(avg_b), 0);
      check({nm, "_flags"}, {28'd0, out_valid, busy, err_timeout, adc_cs}, 0);
      check({nm, "_op_addr"}, {20'd0, adc_op, adc_addr}, 0);
   endtask

   initial begin
      int n, t, vx;

      // reset state
      rst = 1'b1;
      tick();
      check_all_zero("reset");
      tick(); tick();
      rst = 1'b0;
      tick();
      check("post_rst_strobe", {adc_cs, adc_op}, {1'b1, OP_RST});
      tick();
      check("post_rst_idle", {busy, adc_cs}, 0);

      // four forced samples, result held with out_ready low
      push_fixed(100, 104, 108, 112, 16383, 16383, 16383, 16383);
      out_ready = 1'b0;
      run = 1'b1;
      n = 0;
      while (!out_valid && n < 400) begin tick(); n++; end
      check("res1_valid", 32'(out_valid), 1);
      check("res1_avg_a", 32'(avg_a), 106);
      check("res1_avg_b", 32'(avg_b), 16383);
      t = trig_cnt;
      for (int i = 0; i < 20; i++) begin
         tick();
         check("hold_valid", 32'(out_valid), 1);
         check("hold_avg", {avg_a, avg_b}, {14'd106, 14'd16383});
      end
      check("hold_no_trig", 32'(trig_cnt), 32'(t));
      run = 1'b0;
      out_ready = 1'b1;
      tick(); tick();
      check("xfer_clears_valid", 32'(out_valid), 0);

      // run dropped after two samples, resumed 50 cycles later
      push_fixed(100, 104, 108, 112, 16383, 16383, 16383, 16383);
      t = trig_cnt;
      run = 1'b1;
      n = 0;
      while (trig_cnt < t + 2 && n < 200) begin tick(); n++; end
      check("pause_two_trigs", 32'(trig_cnt), 32'(t + 2));
      run = 1'b0;
      repeat (50) tick();
      check("pause_idle", {busy, out_valid}, 0);
      check("pause_no_trig", 32'(trig_cnt), 32'(t + 2));
      run = 1'b1;
      n = 0;
      while (!out_valid && n < 400) begin tick(); n++; end
      check("resume_avg_a", 32'(avg_a), 106);
      check("resume_avg_b", 32'(avg_b), 16383);
      run = 1'b0;
      repeat (5) tick();

      // random samples, random out_ready back-pressure
      vx = xfer_cnt;
      run = 1'b1;
      n = 0;
      while (xfer_cnt < vx + 6 && n < 4000) begin
         out_ready = 1'($urandom_range(0, 1));
         tick();
         n++;
      end
      check("rand_results", 32'(xfer_cnt >= vx + 6), 1);
      run = 1'b0;
      out_ready = 1'b1;
      repeat (80) tick();
      check("rand_drained", 32'(exp_a.size()), 0);

      // adc_rdy never drops: timeout
      stuck = 1'b1;
      clr_gen++;
      t = trig_cnt;
      run = 1'b1;
      n = 0;
      while (trig_cnt == t && n < 100) begin tick(); n++; end
      check("to_trig_seen", 32'(trig_cnt), 32'(t + 1));
      n = 0;
      while (!err_timeout && n < 19) begin tick(); n++; end
      check("to_err_set", 32'(err_timeout), 1);
      check("to_err_in_time", 32'(n <= 18), 1);
      n = 0;
      while (!(adc_cs && adc_op == OP_RST) && n < 3) begin tick(); n++; end
      run = 1'b0;
      check("to_rst_strobe", {adc_cs, adc_op}, {1'b1, OP_RST});
      stuck = 1'b0;
      repeat (5) tick();
      check("to_err_sticky", 32'(err_timeout), 1);

      // reset during WAIT_HI of the third sample
      t = trig_cnt;
      run = 1'b1;
      n = 0;
      while (trig_cnt < t + 3 && n < 300) begin tick(); n++; end
      check("mid_third_trig", 32'(trig_cnt), 32'(t + 3));
      tick(); tick();
      rst = 1'b1;
      clr_gen++;
      push_fixed(1000, 2000, 3000, 4001, 7, 7, 7, 6);
      tick();
      check_all_zero("mid_rst");
      rst = 1'b0;
      tick();
      check("mid_rst_strobe", {adc_cs, adc_op}, {1'b1, OP_RST});
      n = 0;
      while (!out_valid && n < 400) begin tick(); n++; end
      check("fresh_avg_a", 32'(avg_a), 2500);
      check("fresh_avg_b", 32'(avg_b), 6);
      run = 1'b0;
      repeat (5) tick();

      // LOG2_AVG=0 instance
      run0 = 1'b1;
      n = 0;
      while (xfer0 < 3 && n < 500) begin tick(); n++; end
      run0 = 1'b0;
      repeat (10) tick();
      check("raw_results", 32'(xfer0), 3);
      check("raw_trigs", 32'(trig0), 3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

endmodule
